// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 front end: block geometry, pad marker,
// padder FSM states and the big-endian byte-slot helper.
package sha256_pkg;

    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned BLOCK_BYTES = BLOCK_W / 8;
    localparam int unsigned LEN_FIELD_W = 64;
    localparam logic [7:0]  PAD_MARK    = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EMIT
    } padder_state_t;

    // Byte 0 of a block sits in the top byte lane, byte 63 in the bottom one.
    function automatic int unsigned byte_lsb(input int unsigned slot);
        return BLOCK_W - 8 * (slot + 1);
    endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// Decodes the fill pointer into the per-byte masks the PAD cycle needs.
// Bit i of each mask refers to block byte i.
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  logic [6:0]             ptr,
    output logic [BLOCK_BYTES-1:0] keep_mask,
    output logic [BLOCK_BYTES-1:0] mark_onehot,
    output logic                   fits_len
);

    // Bytes below ptr hold message data; the marker goes exactly at ptr.
    always_comb begin
        keep_mask   = '0;
        mark_onehot = '0;
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
            keep_mask[i]   = (7'(i) < ptr);
            mark_onehot[i] = (7'(i) == ptr);
        end
        fits_len = (ptr <= 7'd55);
    end

endmodule

// File: rtl/sha256_padder.sv
// Byte-stream to padded 512-bit block converter for the SHA-256 core.
// Collects bytes into a block buffer, pads in a single cycle, and emits a
// trailing length-only block in place when the length does not fit.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 29
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               in_keep,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_first,
    output logic               blk_last
);

    padder_state_t        state_q, state_d;
    logic [6:0]           ptr_q, ptr_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic [BLOCK_W-1:0]   blk_q, blk_d;
    logic                 first_q, first_d;
    logic                 final_q, final_d;
    logic                 mark_done_q, mark_done_d;
    logic                 len_pend_q, len_pend_d;

    logic [BLOCK_BYTES-1:0] keep_mask;
    logic [BLOCK_BYTES-1:0] mark_onehot;
    logic                   fits_len;
    logic [LEN_FIELD_W-1:0] len_bits;
    logic [BLOCK_W-1:0]     pad_blk;
    logic [BLOCK_W-1:0]     len_blk;

    sha256_pad_mask u_pad_mask (
        .ptr         (ptr_q),
        .keep_mask   (keep_mask),
        .mark_onehot (mark_onehot),
        .fits_len    (fits_len)
    );

    assign len_bits = LEN_FIELD_W'({count_q, 3'b000});

    // Block formed during PAD: kept data, marker, zero fill, optional length.
    always_comb begin
        pad_blk = '0;
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
            if (keep_mask[i]) begin
                pad_blk[byte_lsb(i) +: 8] = blk_q[byte_lsb(i) +: 8];
            end else if (mark_onehot[i]) begin
                pad_blk[byte_lsb(i) +: 8] = PAD_MARK;
            end
        end
        if (fits_len) begin
            pad_blk[LEN_FIELD_W-1:0] = len_bits;
        end
    end

    // Trailing block when the length spilled over; marker only if not yet sent.
    always_comb begin
        len_blk                  = '0;
        len_blk[BLOCK_W-1 -: 8]  = mark_done_q ? 8'h00 : PAD_MARK;
        len_blk[LEN_FIELD_W-1:0] = len_bits;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            ptr_q       <= '0;
            count_q     <= '0;
            blk_q       <= '0;
            first_q     <= 1'b1;
            final_q     <= 1'b0;
            mark_done_q <= 1'b0;
            len_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            blk_q       <= blk_d;
            first_q     <= first_d;
            final_q     <= final_d;
            mark_done_q <= mark_done_d;
            len_pend_q  <= len_pend_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        blk_d       = blk_q;
        first_d     = first_q;
        final_d     = final_q;
        mark_done_d = mark_done_q;
        len_pend_d  = len_pend_q;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (!in_last || in_keep) begin
                        blk_d[byte_lsb(32'(ptr_q[5:0])) +: 8] = in_data;
                        ptr_d   = ptr_q + 7'd1;
                        count_d = count_q + LEN_W'(1);
                    end
                    if (in_last) begin
                        state_d = PAD;
                    end else if (ptr_q == 7'd63) begin
                        state_d = EMIT;
                        final_d = 1'b0;
                    end
                end
            end
            PAD: begin
                blk_d       = pad_blk;
                mark_done_d = !ptr_q[6];
                final_d     = fits_len;
                len_pend_d  = !fits_len;
                state_d     = EMIT;
            end
            EMIT: begin
                if (blk_ready) begin
                    if (len_pend_q) begin
                        blk_d      = len_blk;
                        final_d    = 1'b1;
                        len_pend_d = 1'b0;
                        first_d    = 1'b0;
                    end else if (final_q) begin
                        count_d     = '0;
                        ptr_d       = '0;
                        final_d     = 1'b0;
                        mark_done_d = 1'b0;
                        len_pend_d  = 1'b0;
                        first_d     = 1'b1;
                        state_d     = FILL;
                    end else begin
                        ptr_d   = '0;
                        first_d = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake and block outputs.
    always_comb begin
        in_ready  = (state_q == FILL);
        blk_valid = (state_q == EMIT);
        blk_data  = blk_q;
        blk_first = first_q;
        blk_last  = final_q;
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed self-checking bench for sha256_padder.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_keep;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_keep   (in_keep),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted.
    task automatic send(input logic [7:0] b, input logic last, input logic keep);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        in_keep  = keep;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_keep  = 1'b0;
    endtask

    // Send the first n bytes of a left-aligned message.
    task automatic send_msg(input logic [511:0] msg, input int n, input logic end_last);
        for (int i = 0; i < n; i++) begin
            send(msg[511-8*i -: 8], end_last && (i == n - 1), 1'b1);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!blk_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!blk_valid) begin
            checks++;
            failures++;
            $error("FAIL recv_timeout observed blk_valid=0 expected 1");
        end
    endtask

    task automatic recv(output logic [511:0] d, output logic f, output logic l);
        wait_valid();
        d = blk_data;
        f = blk_first;
        l = blk_last;
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    logic [511:0] abc_msg, abc_blk, empty_blk, m56, b56_1, b56_2, m64, b64_2, d;
    logic [447:0] s56;
    logic         f, l;

    initial begin
        abc_msg   = {24'h616263, 488'h0};
        abc_blk   = {32'h61626380, 416'h0, 64'h18};
        empty_blk = {8'h80, 504'h0};
        s56       = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        m56       = {s56, 64'h0};
        b56_1     = {s56, 8'h80, 56'h0};
        b56_2     = {448'h0, 64'h1c0};
        m64       = 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f_202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
        b64_2     = {8'h80, 440'h0, 64'h200};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_keep   = 1'b0;
        blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_blk_data", blk_data, 0);
        check("rst_blk_first", blk_first, 1);
        check("rst_blk_last", blk_last, 0);

        // "abc" with PAD/EMIT timing
        send_msg(abc_msg, 3, 1'b1);
        check("abc_pad_valid", blk_valid, 0);
        check("abc_pad_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("abc_emit_valid", blk_valid, 1);
        recv(d, f, l);
        check("abc_data", d, abc_blk);
        check("abc_first", f, 1);
        check("abc_last", l, 1);
        check("abc_ready_after", in_ready, 1);

        // Backpressure on an "abc" block
        send_msg(abc_msg, 3, 1'b1);
        wait_valid();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("bp_data", blk_data, abc_blk);
            check("bp_first", blk_first, 1);
            check("bp_last", blk_last, 1);
            check("bp_valid", blk_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        check("bp_release_ready", in_ready, 1);
        send_msg(abc_msg, 3, 1'b1);
        recv(d, f, l);
        check("abc2_data", d, abc_blk);
        check("abc2_first", f, 1);
        check("abc2_last", l, 1);

        // Empty message
        send(8'h00, 1'b1, 1'b0);
        recv(d, f, l);
        check("empty_data", d, empty_blk);
        check("empty_first", f, 1);
        check("empty_last", l, 1);

        // 56-byte message: length spills into a second block
        send_msg(m56, 56, 1'b1);
        recv(d, f, l);
        check("m56_b1_data", d, b56_1);
        check("m56_b1_first", f, 1);
        check("m56_b1_last", l, 0);
        check("m56_no_gap", blk_valid, 1);
        check("m56_b2_early", blk_data, b56_2);
        recv(d, f, l);
        check("m56_b2_data", d, b56_2);
        check("m56_b2_first", f, 0);
        check("m56_b2_last", l, 1);

        // 64-byte message: raw data block, then empty last beat
        send_msg(m64, 64, 1'b0);
        check("m64_valid_n1", blk_valid, 1);
        recv(d, f, l);
        check("m64_b1_data", d, m64);
        check("m64_b1_first", f, 1);
        check("m64_b1_last", l, 0);
        send(8'h00, 1'b1, 1'b0);
        recv(d, f, l);
        check("m64_b2_data", d, b64_2);
        check("m64_b2_first", f, 0);
        check("m64_b2_last", l, 1);

        // Reset mid-message, then "abc"
        send_msg(m64, 30, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_blk_valid", blk_valid, 0);
        check("midrst_blk_data", blk_data, 0);
        check("midrst_blk_first", blk_first, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_msg(abc_msg, 3, 1'b1);
        recv(d, f, l);
        check("midrst_abc_data", d, abc_blk);
        check("midrst_abc_first", f, 1);
        check("midrst_abc_last", l, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Byte-stream front end for the uPcoin SHA-256 hasher. Accepts message bytes one per cycle and emits complete 512-bit big-endian blocks: data, the 0x80 marker, zero fill and the 64-bit bit-length. It sits directly upstream of the hash core and replaces host-side pre-padding. The `blk_first` and `blk_last` outputs tell the core when to reload the IV and when the final block has been delivered.

## Interface
- `LEN_W`, default 29: width of the message byte counter. The bit length is the byte count shifted left by 3, zero-extended to 64 bits.
- `clk` in, 1: the single clock. Everything is rising-edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: input byte present.
- `in_ready` out, 1: padder can accept a byte this cycle.
- `in_data` in, 8: message byte, MSB-first within the block.
- `in_last` in, 1: this beat ends the message.
- `in_keep` in, 1: `in_data` is a real byte. Ignored unless `in_last` = 1. `in_last`=1 with `in_keep`=0 ends the message with no byte, which is how an empty message is sent.
- `blk_valid` out, 1: `blk_data` holds a complete block.
- `blk_ready` in, 1: hash core accepts the block.
- `blk_data` out, 512: the block. Byte 0 is at [511:504].
- `blk_first` out, 1: this is the first block of a message (core reloads the IV).
- `blk_last` out, 1: this is the final block of the message (core may assert `done` after it).

## Operation
State machine with states FILL, PAD, EMIT.

- **FILL**
  - `in_ready` = 1.
  - On each handshake, a kept byte is written to byte slot `ptr`, then `ptr` and `count` increment.
  - Byte at `ptr` = 63 without `in_last`: go to EMIT with `final` = 0.
  - Any `in_last` beat: go to PAD. Here `ptr` can be 0..64.
- **PAD** (exactly one cycle, `in_ready` = 0)
  - If `ptr` < 64: write 0x80 at `ptr` and set `mark_done`.
  - Zero bytes `ptr`+1..63.
  - If `ptr` <= 55: write the length at bytes 56..63 (big-endian) and set `final` = 1.
  - Otherwise: set `len_pend` = 1 and `final` = 0.
  - Next state is EMIT.
- **EMIT**
  - `blk_valid` = 1, `in_ready` = 0.
  - On `blk_valid` & `blk_ready`:
    - If `len_pend`: build the next block in place. Byte 0 = 0x80 if not `mark_done`, else 0x00. Bytes 1..55 = 0. Bytes 56..63 = length. Set `final` = 1, clear `len_pend`, stay in EMIT.
    - Else if `final`: clear `count`, `ptr` and the flags, set `first` = 1, go to FILL.
    - Else: `ptr` = 0, `first` = 0, go to FILL.
- **Output flags:** `blk_first` = `first` and `blk_last` = `final`, both registered and valid whenever `blk_valid` = 1.
- **Counter wrap:** `count` wraps modulo 2^`LEN_W`. Messages of 2^`LEN_W` bytes or more produce a truncated length field; this is unsupported by design.
- **Input while not ready:** a beat presented with `in_valid` while `in_ready` = 0 is not consumed. The source must hold it.

## Timing
- **Reset values:** state FILL, `in_ready` = 1, `blk_valid` = 0, `blk_data` = 0, `blk_first` = 1 (internal `first`), `blk_last` = 0, `ptr` = 0, `count` = 0.
- **Full data block:** byte 63 accepted in cycle N, `blk_valid` high in cycle N+1.
- **`in_last` block:** `in_last` accepted in cycle N, PAD in N+1, `blk_valid` in N+2.
- **Second (length) block:** `blk_valid` stays high with no gap. The new `blk_data` appears in the cycle after the first block's handshake.
- **Return to FILL:** `in_ready` rises in the cycle after the final handshake.
- **Stability:** `blk_data`, `blk_first` and `blk_last` are stable while `blk_valid` & !`blk_ready`.
- **Throughput:** a 64-byte data block costs 64 fill cycles plus at least 1 emit cycle. There is no overlap between filling and emitting.
- **Reset mid-operation:** `reset_n` low in any state aborts the message immediately. Outputs return to reset values; no partial block is emitted.

## Structure
- Shared package `sha256_pkg` holds:
  - `BLOCK_W` = 512 and `LEN_FIELD_W` = 64.
  - `PAD_MARK` = 8'h80.
  - The `padder_state_t` enum {FILL, PAD, EMIT}.
  - The big-endian byte-slot helper function.
- One combinational sub-module, `sha256_pad_mask`:
  - Input: `ptr` (7 bits).
  - Outputs: a 64-bit keep mask (bytes < `ptr`), a one-hot marker position, and the `fits_len` flag (`ptr` <= 55).
  - PAD uses these outputs to form the block in one cycle.

## Test plan
- **"abc":** 616263 with `in_last` on 0x63 → one block 0x6162638000…0018, `blk_first` = `blk_last` = 1.
- **Empty message:** `in_last`=1, `in_keep`=0 → one block 0x80 followed by 63 zero bytes (length 0), `first` = `last` = 1.
- **56-byte message "abcdbcdecdef…nopq":**
  - Block 1 = data + 0x80 + 7 zero bytes, `first` = 1, `last` = 0.
  - Block 2 = zeros + 0x00000000000001C0, `first` = 0, `last` = 1.
- **64-byte message:**
  - Block 1 = raw data, `last` = 0, `blk_valid` one cycle after byte 63.
  - Block 2 = 0x80, zeros, length 0x0200, `last` = 1.
- **Backpressure:** hold `blk_ready` low for 20 cycles on the "abc" block → `blk_data` and flags unchanged, `in_ready` = 0. Release → `in_ready` = 1 the next cycle. A second "abc" message then shows `blk_first` = 1 again.
- **Reset mid-message:** pulse `reset_n` low after 30 bytes, then send "abc" → output identical to the first scenario; no stale bytes and length 0x18.
